// File: rtl/chi_inv.sv
`default_nettype none
// ============================================================================
// chi_inv : iterative inverse of Keccak-f[1600] chi, one y-plane per cycle.
// Optional macro CHI_INV_SELFCHECK_EN adds a forward-chi self-check (chk_err).
// Revision: 1.0
// ============================================================================
module chi_inv (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4:0][4:0][63:0]  chi_in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4:0][4:0][63:0]  chi_out_data
`ifdef CHI_INV_SELFCHECK_EN
    ,
    output logic                   chk_err
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic logic [4:0] chi5(input logic [4:0] a);
        logic [4:0] b;
        for (int x = 0; x < 5; x++) begin
            b[x] = a[x] ^ (~a[(x + 1) % 5] & a[(x + 2) % 5]);
        end
        return b;
    endfunction

    // chi is a bijection on 5-bit rows, so scattering every v to slot chi5(v)
    // yields the complete inverse table at elaboration time.
    function automatic logic [159:0] build_inv5();
        logic [159:0] t;
        t = '0;
        for (int v = 0; v < 32; v++) begin
            t[int'(chi5(5'(v))) * 5 +: 5] = 5'(v);
        end
        return t;
    endfunction

    localparam logic [159:0] INV5_TBL = build_inv5();

    logic [1:0]               state;
    logic [2:0]               y_cnt;
    logic [4:0][4:0][63:0]    st;
    logic [4:0][4:0][63:0]    st_nxt;
    logic [4:0]               row;
    logic [4:0]               row_inv;

    assign in_ready = (state == S_IDLE);

    always_comb begin
        st_nxt  = st;
        row     = '0;
        row_inv = '0;
        for (int y = 0; y < 5; y++) begin
            if (y_cnt == 3'(y)) begin
                for (int z = 0; z < 64; z++) begin
                    for (int x = 0; x < 5; x++) begin
                        row[x] = st[x][y][z];
                    end
                    row_inv = INV5_TBL[int'(row) * 5 +: 5];
                    for (int x = 0; x < 5; x++) begin
                        st_nxt[x][y][z] = row_inv[x];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            y_cnt        <= 3'd0;
            st           <= '0;
            out_valid    <= 1'b0;
            chi_out_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        st    <= chi_in_data;
                        y_cnt <= 3'd0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    st <= st_nxt;
                    if (y_cnt == 3'd4) begin
                        y_cnt        <= 3'd0;
                        state        <= S_DONE;
                        out_valid    <= 1'b1;
                        chi_out_data <= st_nxt;
                    end else begin
                        y_cnt <= y_cnt + 3'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state        <= S_IDLE;
                        out_valid    <= 1'b0;
                        chi_out_data <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CHI_INV_SELFCHECK_EN
    logic [4:0][4:0][63:0] in_shadow;
    logic [4:0][4:0][63:0] fwd;

    always_comb begin
        fwd = '0;
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                fwd[x][y] = st[x][y] ^ (~st[(x + 1) % 5][y] & st[(x + 2) % 5][y]);
            end
        end
    end

    // Output is held stable in DONE, so checking every DONE cycle is
    // equivalent to checking the first one.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_shadow <= '0;
            chk_err   <= 1'b0;
        end else begin
            if (state == S_IDLE && in_valid) begin
                in_shadow <= chi_in_data;
            end
            if (state == S_DONE && fwd != in_shadow) begin
                chk_err <= 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_chi_inv.sv
`default_nettype none
// tb_chi_inv : scoreboard bench for chi_inv (directed, random round-trip, reset abort).
module tb_chi_inv;

    typedef logic [4:0][4:0][63:0] st_t;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic out_ready;
    st_t  chi_in_data;
    st_t  chi_out_data;
`ifdef CHI_INV_SELFCHECK_EN
    logic chk_err;
`endif

    int   checks   = 0;
    int   failures = 0;
    st_t  sb[$];

    always #5 clk = ~clk;

    chi_inv dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .chi_in_data  (chi_in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .chi_out_data (chi_out_data)
`ifdef CHI_INV_SELFCHECK_EN
        ,
        .chk_err      (chk_err)
`endif
    );

    task automatic check_eq(input string tag, input logic [1599:0] got, input logic [1599:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got[63:0]=%h exp[63:0]=%h bits_differing=%0d",
                     tag, got[63:0], exp[63:0], $countones(got ^ exp));
        end
    endtask

    function automatic st_t chi_ref(input st_t a);
        st_t b;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                for (int z = 0; z < 64; z++)
                    b[x][y][z] = a[x][y][z] ^ (~a[(x + 1) % 5][y][z] & a[(x + 2) % 5][y][z]);
        return b;
    endfunction

    function automatic st_t rand_state();
        st_t r;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                r[x][y] = {$urandom(), $urandom()};
        return r;
    endfunction

    task automatic run_job(input st_t din, input st_t exp, input int stall);
        int  n;
        st_t exp_q;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("in_ready_before_accept", 1600'(in_ready), 1600'(1));
        chi_in_data = din;
        in_valid    = 1'b1;
        out_ready   = (stall == 0);
        sb.push_back(exp);
        @(posedge clk); #1;
        // keep offering garbage while busy; it must be ignored
        in_valid    = $urandom_range(0, 1) == 1;
        chi_in_data = rand_state();
        check_eq("in_ready_busy", 1600'(in_ready), 1600'(0));
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("latency", 1600'(n), 1600'(5));
        if (!out_valid) begin
            void'(sb.pop_front());
            in_valid = 1'b0;
            return;
        end
        check_eq("no_overlap", 1600'(in_ready), 1600'(0));
        for (int k = 0; k < stall; k++) begin
            check_eq("stall_hold", chi_out_data, sb[0]);
            check_eq("stall_valid", 1600'(out_valid), 1600'(1));
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        exp_q = sb.pop_front();
        check_eq("result", chi_out_data, exp_q);
        @(posedge clk); #1;
        check_eq("post_out_valid", 1600'(out_valid), 1600'(0));
        check_eq("post_in_ready", 1600'(in_ready), 1600'(1));
        check_eq("post_data_zero", chi_out_data, 1600'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        st_t t;
        st_t orig;
        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        chi_in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 1600'(in_ready), 1600'(1));
        check_eq("rst_out_valid", 1600'(out_valid), 1600'(0));
        check_eq("rst_data", chi_out_data, 1600'(0));
        rst = 1'b0;

        run_job('0, '0, 0);
        run_job('1, '1, 0);

        t = '0;
        t[0][2][17] = 1'b1;
        t[3][2][17] = 1'b1;
        orig = '0;
        orig[0][2][17] = 1'b1;
        run_job(t, orig, 2);

        for (int i = 0; i < 1000; i++) begin
            orig = rand_state();
            run_job(chi_ref(orig), orig, $urandom_range(0, 10));
        end

        // abort mid-RUN
        chi_in_data = rand_state();
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("abort_out_valid", 1600'(out_valid), 1600'(0));
        check_eq("abort_in_ready", 1600'(in_ready), 1600'(1));
        check_eq("abort_data", chi_out_data, 1600'(0));
        rst = 1'b0;
        run_job('1, '1, 3);

`ifdef CHI_INV_SELFCHECK_EN
        check_eq("chk_err_clean", 1600'(chk_err), 1600'(0));
`endif
        check_eq("sb_empty", 1600'(sb.size()), 1600'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
